fifo_ctrl: RTL
==============

// Module: fifo_ctrl
// PURPOSE
//  Pointer/flag controller for the 8x10 dual-port FIFO memory (write_addr/read_addr/enables).
//  Turns push/pop requests into memory enables and addresses, tracks occupancy, and raises
//  full/empty, almost-full/almost-empty, error and read-data-valid. Sits between the
//  requesting logic and the memory; the memory data path (Fifo_Data_in/out) bypasses it.
// PARAMETERS
//  MEM_WIDTH   10  data width of the controlled memory (informational, no data path here)
//  ADDR_WIDTH  3   pointer width; depth DEPTH = 2**ADDR_WIDTH (= 8 rows)
// PORTS
//  clk           in   1             clock, all state updates on posedge
//  reset         in   1             synchronous, active-high reset
//  push          in   1             write request; data presented to memory by requester
//  pop           in   1             read request
//  af_thresh     in   ADDR_WIDTH+1  almost-full threshold (count >= af_thresh)
//  ae_thresh     in   ADDR_WIDTH+1  almost-empty threshold (count <= ae_thresh)
//  write_enable  out  1             memory write strobe (accepted push)
//  read_enable   out  1             memory read strobe (accepted pop)
//  write_addr    out  ADDR_WIDTH    memory write address = write pointer
//  read_addr     out  ADDR_WIDTH    memory read address = read pointer
//  count         out  ADDR_WIDTH+1  occupancy, 0..DEPTH
//  full, empty   out  1             count==DEPTH / count==0
//  almost_full   out  1             count >= af_thresh
//  almost_empty  out  1             count <= ae_thresh
//  data_valid    out  1             memory Fifo_Data_out holds popped word this cycle
//  error         out  1             overflow/underflow indication
// BEHAVIOUR
//  - Reset (sync, high): wr_ptr=rd_ptr=0, count=0, data_valid=0, error=0; enables forced 0
//    while reset high; after reset empty=1, full=0, almost_full/almost_empty per thresholds.
//  - Accept: push_ok = push & ~full; pop_ok = pop & ~empty; both from registered count.
//    write_enable=push_ok, read_enable=pop_ok (combinational, same cycle as request);
//    addresses are the registered pointers, so memory acts on the same posedge.
//  - On posedge: push_ok -> wr_ptr+1; pop_ok -> rd_ptr+1; count += push_ok - pop_ok.
//    Pointers wrap DEPTH-1 -> 0 by natural ADDR_WIDTH overflow.
//  - Simultaneous push&pop: neither full nor empty -> both accepted, count unchanged.
//    Full -> pop accepted, push rejected (no same-address read/write). Empty -> push
//    accepted, pop rejected.
//  - Flags combinational from registered count: change the cycle after the accept edge.
//  - data_valid: register of pop_ok; high exactly one cycle after each accepted pop
//    (1-cycle registered memory read latency).
//  - error: registered (push & full) | (pop & empty); behaviour per CONFIGURATION.
//  - Reset mid-operation: all state cleared at that edge; memory contents not cleared,
//    in-flight data_valid dropped.
//  - Thresholds > DEPTH: almost_full never asserts; ae_thresh >= DEPTH: almost_empty stuck 1.
// CONFIGURATION
//  FIFO_CTRL_STICKY_ERR_EN defined: error latches 1 on first overflow/underflow, held
//    until reset. Undefined (default): error is a 1-cycle pulse the cycle after each
//    rejected request.
// TESTING
//  1 reset, push 3 cycles (data 0x091,0x04A,0x093) -> write_enable=1, write_addr 0,1,2;
//    then count=3, empty=0, read_enable=0 throughout.
//  2 pop 3 cycles -> read_addr 0,1,2, read_enable=1; data_valid 1 cycle later each,
//    memory out 0x091,0x04A,0x093; count=0, empty=1 after last edge.
//  3 push 9 from empty -> full=1 after 8th; 9th push write_enable=0, count stays 8,
//    error pulse (or sticky with FIFO_CTRL_STICKY_ERR_EN); pop on empty -> read_enable=0, error.
//  4 count=4, wr_ptr=7: push&pop 1 cycle -> both enables 1, count=4, wr_ptr 7->0 (wrap);
//    push&pop at full -> only pop accepted, count=7; at empty -> only push, count=1.
//  5 af_thresh=6, ae_thresh=1: pushes -> almost_empty 1 at count 0..1, almost_full at 6..8.
//  6 reset high at count=5 mid-push -> next cycle count=0, empty=1, ptrs=0, data_valid=0.

Source files
------------

// File: rtl/fifo_ctrl_if.sv
// Requester-side handshake bundle for the FIFO pointer/flag controller.
// Carries push/pop requests, thresholds, memory strobes/addresses and status flags.
interface fifo_ctrl_if #(
  parameter int ADDR_WIDTH = 3
);
  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH:0]   af_thresh;
  logic [ADDR_WIDTH:0]   ae_thresh;
  logic                  write_enable;
  logic                  read_enable;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [ADDR_WIDTH-1:0] read_addr;
  logic [ADDR_WIDTH:0]   count;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  data_valid;
  logic                  error;

  modport master (
    output push, pop, af_thresh, ae_thresh,
    input  write_enable, read_enable,
    input  write_addr, read_addr, count,
    input  full, empty, almost_full, almost_empty,
    input  data_valid, error
  );

  modport slave (
    input  push, pop, af_thresh, ae_thresh,
    output write_enable, read_enable,
    output write_addr, read_addr, count,
    output full, empty, almost_full, almost_empty,
    output data_valid, error
  );
endinterface

// File: rtl/fifo_ctrl.sv
// Pointer/flag controller for an 8x10 dual-port FIFO memory.
// Define FIFO_CTRL_STICKY_ERR_EN to make error latch until reset.
module fifo_ctrl #(
  parameter int MEM_WIDTH  = 10,
  parameter int ADDR_WIDTH = 3
) (
  input  logic       clk,
  input  logic       reset,
  fifo_ctrl_if.slave bus
);
  // memory width has no data path here; it only travels with the config
  localparam int AW = ADDR_WIDTH + 0 * MEM_WIDTH;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(1 << AW);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          dv;
  logic          err;
  logic          full;
  logic          empty;
  logic          push_ok;
  logic          pop_ok;
  logic          bad;

  assign full    = (cnt == DEPTH);
  assign empty   = (cnt == '0);
  assign push_ok = bus.push & ~full & ~reset;
  assign pop_ok  = bus.pop & ~empty & ~reset;
  assign bad     = (bus.push & full) | (bus.pop & empty);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      dv     <= 1'b0;
      err    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(push_ok) - CW'(pop_ok);
      dv  <= pop_ok;
`ifdef FIFO_CTRL_STICKY_ERR_EN
      err <= err | bad;
`else
      err <= bad;
`endif
    end
  end

  assign bus.write_enable = push_ok;
  assign bus.read_enable  = pop_ok;
  assign bus.write_addr   = wr_ptr;
  assign bus.read_addr    = rd_ptr;
  assign bus.count        = cnt;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (cnt >= bus.af_thresh);
  assign bus.almost_empty = (cnt <= bus.ae_thresh);
  assign bus.data_valid   = dv;
  assign bus.error        = err;
endmodule
